// File: rtl/wb_arb_mux.sv
// Round-robin multi-master wishbone arbiter feeding a one-hot slave decoder,
// with bus-hold grants and a per-transfer timeout that turns a hung slave into err.
module wb_arb_mux #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int SLAVES     = 4,
  parameter int MASTERS    = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [MASTERS-1:0]                    m_cyc,
  input  logic [MASTERS-1:0]                    m_stb,
  input  logic [MASTERS-1:0]                    m_we,
  input  logic [(ADDR_WIDTH+SLAVES)*MASTERS-1:0] m_addr,
  input  logic [DATA_WIDTH*MASTERS-1:0]         m_data_write,
  output logic [MASTERS-1:0]                    m_ack,
  output logic [MASTERS-1:0]                    m_err,
  output logic [DATA_WIDTH-1:0]                 m_data_read,
  input  logic [SLAVES-1:0]                     s_ack,
  input  logic [SLAVES-1:0]                     s_err,
  output logic [SLAVES-1:0]                     s_cyc,
  output logic [SLAVES-1:0]                     s_stb,
  output logic [SLAVES-1:0]                     s_we,
  output logic [ADDR_WIDTH*SLAVES-1:0]          s_addr,
  output logic [DATA_WIDTH*SLAVES-1:0]          s_data_write,
  input  logic [DATA_WIDTH*SLAVES-1:0]          s_data_read
);

  localparam int FW = ADDR_WIDTH + SLAVES;
  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic          busy;
  logic [GW-1:0] gnt;
  logic [GW-1:0] nxt_gnt;
  logic          found;
  logic [TW-1:0] tcnt;
  logic [FW-1:0] g_addr;
  logic [SW-1:0] sel;
  logic          selected;
  logic          active;
  logic          w;
  logic          tfire;

  always_comb begin
    g_addr   = m_addr[int'(gnt)*FW +: FW];
    active   = busy && m_cyc[gnt];
    sel      = '0;
    selected = 1'b0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (g_addr[ADDR_WIDTH+i]) begin
        sel      = SW'(i);
        selected = 1'b1;
      end
    end
    w     = active && m_stb[gnt] && selected
            && !s_ack[sel] && !s_err[sel];
    tfire = (TIMEOUT > 0) && w && (tcnt == TW'(TIMEOUT));
  end

  // search starts just past the current holder, so it ends on it
  always_comb begin
    nxt_gnt = gnt;
    found   = 1'b0;
    for (int k = 1; k <= MASTERS; k++) begin
      if (!found && m_cyc[(int'(gnt) + k) % MASTERS]) begin
        found   = 1'b1;
        nxt_gnt = GW'((int'(gnt) + k) % MASTERS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      gnt  <= GW'(MASTERS - 1);
      tcnt <= '0;
    end else begin
      if (!busy || !m_cyc[gnt]) begin
        busy <= found;
        gnt  <= nxt_gnt;
      end
      if ((TIMEOUT > 0) && w && !tfire)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
    end
  end

  always_comb begin
    m_ack        = '0;
    m_err        = '0;
    s_cyc        = '0;
    s_stb        = '0;
    m_data_read  = 'x;
    s_we         = {SLAVES{m_we[gnt]}};
    s_addr       = {SLAVES{g_addr[ADDR_WIDTH-1:0]}};
    s_data_write = {SLAVES{m_data_write[int'(gnt)*DATA_WIDTH +: DATA_WIDTH]}};
    if (active) begin
      s_cyc = '1;
      if (selected) begin
        s_stb[sel]  = m_stb[gnt] && !tfire;
        m_ack[gnt]  = s_ack[sel];
        m_err[gnt]  = s_err[sel] || tfire;
        m_data_read = s_data_read[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        m_err[gnt] = m_stb[gnt];
      end
    end
  end

endmodule

// File: tb/tb_wb_arb_mux.sv
// Self-checking bench for wb_arb_mux: directed scenarios plus randomized
// traffic against a behavioural owner/wait-count model.
module tb_wb_arb_mux;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int S  = 4;
  localparam int M  = 2;
  localparam int TO = 15;
  localparam int FW = AW + S;

  logic clk = 0;
  logic rst = 1;
  logic [M-1:0] m_cyc, m_stb, m_we;
  logic [M*FW-1:0] m_addr;
  logic [M*DW-1:0] m_data_write;
  logic [M-1:0] m_ack, m_err, z_m_ack, z_m_err;
  logic [DW-1:0] m_data_read, z_m_data_read;
  logic [S-1:0] s_ack, s_err;
  logic [S-1:0] s_cyc, s_stb, s_we, z_s_cyc, z_s_stb, z_s_we;
  logic [S*AW-1:0] s_addr, z_s_addr;
  logic [S*DW-1:0] s_data_write, z_s_data_write, s_data_read;

  int n_checks = 0;
  int n_fail = 0;

  int mbusy, mg, mt;

  always #5 clk = ~clk;

  wb_arb_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVES(S),
               .MASTERS(M), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_data_write(m_data_write), .m_ack(m_ack),
    .m_err(m_err), .m_data_read(m_data_read), .s_ack(s_ack),
    .s_err(s_err), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_addr(s_addr), .s_data_write(s_data_write),
    .s_data_read(s_data_read));

  wb_arb_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVES(S),
               .MASTERS(M), .TIMEOUT(0)) dut_noto (
    .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_data_write(m_data_write), .m_ack(z_m_ack),
    .m_err(z_m_err), .m_data_read(z_m_data_read), .s_ack(s_ack),
    .s_err(s_err), .s_cyc(z_s_cyc), .s_stb(z_s_stb), .s_we(z_s_we),
    .s_addr(z_s_addr), .s_data_write(z_s_data_write),
    .s_data_read(s_data_read));

  task automatic model_reset();
    mbusy = 0;
    mg = M - 1;
    mt = 0;
  endtask

  function automatic int target(int g);
    int sel = -1;
    for (int i = S - 1; i >= 0; i--)
      if (m_addr[g*FW+AW+i]) sel = i;
    return sel;
  endfunction

  // expected outputs: owner g talks to the lowest selected slave
  task automatic model_exp(output logic [M-1:0] ea, output logic [M-1:0] ee,
                           output logic [S-1:0] ecyc, output logic [S-1:0] estb,
                           output int esel, output bit eact);
    bit fire;
    ea = '0; ee = '0; ecyc = '0; estb = '0;
    eact = (mbusy != 0) && m_cyc[mg];
    esel = eact ? target(mg) : -1;
    if (eact) begin
      ecyc = '1;
      if (esel < 0) begin
        ee[mg] = m_stb[mg];
      end else begin
        fire = TO > 0 && mt == TO && m_stb[mg]
               && !s_ack[esel] && !s_err[esel];
        ea[mg] = s_ack[esel];
        ee[mg] = s_err[esel] || fire;
        estb[esel] = m_stb[mg] && !fire;
      end
    end
  endtask

  task automatic tick();
    bit act, w, found;
    int sel;
    act = (mbusy != 0) && m_cyc[mg];
    sel = act ? target(mg) : -1;
    w = 0;
    if (act && m_stb[mg] && sel >= 0)
      w = !s_ack[sel] && !s_err[sel];
    @(posedge clk);
    mt = (w && mt < TO) ? mt + 1 : 0;
    if (mbusy == 0 || !m_cyc[mg]) begin
      found = 0;
      for (int k = 1; k <= M; k++)
        if (!found && m_cyc[(mg + k) % M]) begin
          found = 1;
          mg = (mg + k) % M;
        end
      mbusy = found;
    end
    #1;
  endtask

  task automatic clear_in();
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0;
    m_data_write = '0; s_ack = '0; s_err = '0; s_data_read = '0;
  endtask

  task automatic set_m(int k, bit c, bit st, logic [FW-1:0] a);
    m_cyc[k] = c;
    m_stb[k] = st;
    m_addr[k*FW +: FW] = a;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_in();
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    m_cyc = '1; m_stb = '1; s_ack = '1; s_err = '1;
    #1;
    n_checks++;
    if ({s_cyc, s_stb, m_ack, m_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h required 0",
               {s_cyc, s_stb, m_ack, m_err});
    end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({s_cyc, s_stb, m_ack, m_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: cyc %0d got %h required 0", c,
                 {s_cyc, s_stb, m_ack, m_err});
      end
    end
  endtask

  task automatic test_read();
    do_reset();
    s_data_read = {$urandom, $urandom};
    set_m(0, 1, 1, {4'b0010, 5'h03});
    #1;
    n_checks++;
    if (s_stb !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_latency: s_stb got %b required 0000", s_stb);
    end
    tick();
    n_checks++;
    if (s_stb !== 4'b0010 || s_cyc !== 4'b1111 || m_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL read_strobe: stb %b cyc %b ack %b required 0010 1111 00",
               s_stb, s_cyc, m_ack);
    end
    n_checks++;
    if (s_addr[AW +: AW] !== 5'h03) begin
      n_fail++;
      $display("FAIL read_addr: got %h required 03", s_addr[AW +: AW]);
    end
    s_ack = 4'b0010;
    s_data_read[DW +: DW] = 16'hBEEF;
    #1;
    n_checks++;
    if (m_ack !== 2'b01 || m_err !== 2'b00 || m_data_read !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL read_ack: ack %b err %b data %h required 01 00 beef",
               m_ack, m_err, m_data_read);
    end
    tick();
    clear_in();
  endtask

  task automatic test_arbitration();
    int exp_g;
    do_reset();
    s_ack = 4'b0001;
    set_m(0, 1, 1, {4'b0001, 5'h01});
    set_m(1, 1, 1, {4'b0001, 5'h02});
    tick();
    n_checks++;
    if (s_addr[0 +: AW] !== 5'h01 || m_ack !== 2'b01) begin
      n_fail++;
      $display("FAIL arb_first: addr %h ack %b required 01 01",
               s_addr[0 +: AW], m_ack);
    end
    exp_g = 0;
    for (int r = 0; r < 3; r++) begin
      m_cyc[exp_g] = 0;
      tick();
      m_cyc[exp_g] = 1;
      exp_g = 1 - exp_g;
      #1;
      n_checks++;
      if (s_addr[0 +: AW] !== 5'(exp_g + 1) || m_ack !== 2'(1 << exp_g)) begin
        n_fail++;
        $display("FAIL arb_alternate: round %0d addr %h ack %b required %0d %b",
                 r, s_addr[0 +: AW], m_ack, exp_g + 1, 2'(1 << exp_g));
      end
    end
    clear_in();
    tick();
  endtask

  task automatic test_decode_err();
    do_reset();
    set_m(1, 1, 1, {4'b0000, 5'h07});
    tick();
    n_checks++;
    if (m_err !== 2'b10 || s_stb !== 4'b0000 || m_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL decode_none: err %b stb %b ack %b required 10 0000 00",
               m_err, s_stb, m_ack);
    end
    m_addr[FW +: FW] = {4'b1010, 5'h07};
    #1;
    n_checks++;
    if (s_stb !== 4'b0010 || m_err !== 2'b00) begin
      n_fail++;
      $display("FAIL decode_lowest: stb %b err %b required 0010 00",
               s_stb, m_err);
    end
    clear_in();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    set_m(0, 1, 1, {4'b0100, 5'h09});
    tick();
    for (int n = 1; n <= TO; n++) begin
      n_checks++;
      if (m_err !== 2'b00 || s_stb !== 4'b0100 || z_m_err !== 2'b00) begin
        n_fail++;
        $display("FAIL timeout_wait: cycle %0d err %b stb %b err0 %b",
                 n, m_err, s_stb, z_m_err);
      end
      tick();
    end
    n_checks++;
    if (m_err !== 2'b01 || s_stb !== 4'b0000 || z_m_err !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_fire: err %b stb %b err0 %b required 01 0000 00",
               m_err, s_stb, z_m_err);
    end
    tick();
    for (int n = 1; n <= TO; n++) tick();
    s_ack = 4'b0100;
    #1;
    n_checks++;
    if (m_ack !== 2'b01 || m_err !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_ack_wins: ack %b err %b required 01 00",
               m_ack, m_err);
    end
    clear_in();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_m(1, 1, 1, {4'b0001, 5'h05});
    for (int c = 0; c < 5; c++) tick();
    n_checks++;
    if (s_stb !== 4'b0001) begin
      n_fail++;
      $display("FAIL arst_pre: stb %b required 0001", s_stb);
    end
    #2;
    rst = 1;
    model_reset();
    s_ack = 4'b0001;
    #1;
    n_checks++;
    if ({s_cyc, s_stb, m_ack, m_err} !== '0) begin
      n_fail++;
      $display("FAIL arst_drop: got %h required 0",
               {s_cyc, s_stb, m_ack, m_err});
    end
    s_ack = '0;
    set_m(0, 1, 1, {4'b0100, 5'h00});
    set_m(1, 1, 1, {4'b0100, 5'h1f});
    @(negedge clk);
    rst = 0;
    tick();
    n_checks++;
    if (s_addr[2*AW +: AW] !== 5'h00 || s_stb !== 4'b0100) begin
      n_fail++;
      $display("FAIL arst_m0_first: addr %h stb %b required 00 0100",
               s_addr[2*AW +: AW], s_stb);
    end
    for (int n = 1; n <= TO; n++) tick();
    n_checks++;
    if (m_err !== 2'b01) begin
      n_fail++;
      $display("FAIL arst_tcnt: err %b required 01", m_err);
    end
    clear_in();
    tick();
  endtask

  task automatic test_random();
    logic [M-1:0] ea, ee;
    logic [S-1:0] ecyc, estb;
    int esel;
    bit eact;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < M; k++) begin
        m_cyc[k] = $urandom_range(0, 4) != 0;
        m_stb[k] = $urandom_range(0, 3) != 0;
        m_we[k]  = 1'($urandom);
      end
      m_addr = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) m_addr[mg*FW+AW +: S] = '0;
      m_data_write = $urandom;
      s_data_read = {$urandom, $urandom};
      for (int i = 0; i < S; i++) begin
        s_ack[i] = ((c % 100) < 60) && $urandom_range(0, 3) == 0;
        s_err[i] = ((c % 100) < 60) && $urandom_range(0, 15) == 0;
      end
      #1;
      model_exp(ea, ee, ecyc, estb, esel, eact);
      n_checks++;
      if (m_ack !== ea || m_err !== ee || s_cyc !== ecyc || s_stb !== estb) begin
        n_fail++;
        $display("FAIL rand_ctl: c %0d ack %b/%b err %b/%b cyc %b/%b stb %b/%b",
                 c, m_ack, ea, m_err, ee, s_cyc, ecyc, s_stb, estb);
      end
      if (eact) begin
        n_checks++;
        if (s_addr[0 +: AW] !== m_addr[mg*FW +: AW]
            || s_we[0] !== m_we[mg]
            || s_data_write[0 +: DW] !== m_data_write[mg*DW +: DW]) begin
          n_fail++;
          $display("FAIL rand_bcast: c %0d addr %h required %h", c,
                   s_addr[0 +: AW], m_addr[mg*FW +: AW]);
        end
      end
      if (eact && esel >= 0) begin
        n_checks++;
        if (m_data_read !== s_data_read[esel*DW +: DW]) begin
          n_fail++;
          $display("FAIL rand_rdata: c %0d got %h required %h", c,
                   m_data_read, s_data_read[esel*DW +: DW]);
        end
      end
      tick();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_read();
    test_arbitration();
    test_decode_err();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
